// File: rtl/mac_dot_product_engine_if.sv
// Handshake and bank-write bundle for mac_dot_product_engine.
// master: a_*/b_* bank writes and start; slave: busy, c_out, c_valid, done.
interface mac_dot_product_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic signed [DATA_WIDTH-1:0]   a_wdata;
    logic        [ADDR_WIDTH-1:0]   a_addr;
    logic                           a_wen;
    logic signed [DATA_WIDTH-1:0]   b_wdata;
    logic        [ADDR_WIDTH-1:0]   b_addr;
    logic                           b_wen;
    logic                           start;
    logic                           busy;
    logic signed [2*DATA_WIDTH-1:0] c_out;
    logic                           c_valid;
    logic                           done;

    modport master (
        output a_wdata, a_addr, a_wen,
        output b_wdata, b_addr, b_wen,
        output start,
        input  busy, c_out, c_valid, done
    );

    modport slave (
        input  a_wdata, a_addr, a_wen,
        input  b_wdata, b_addr, b_wen,
        input  start,
        output busy, c_out, c_valid, done
    );
endinterface

// File: rtl/mac_dot_product_engine.sv
// Signed N-tap dot product, one MAC per cycle, start/done handshake.
// Ports: clk, rst (sync, active-high), bus (slave modport of
// mac_dot_product_engine_if). Define MAC_DOT_SAT_EN to saturate c_out.
module mac_dot_product_engine #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input logic                      clk,
    input logic                      rst,
    mac_dot_product_engine_if.slave  bus
);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = PW + ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0]   N_LIM = (ADDR_WIDTH + 1)'(N);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state;

    logic signed [DATA_WIDTH-1:0] a_bank [N];
    logic signed [DATA_WIDTH-1:0] b_bank [N];

    logic        [ADDR_WIDTH-1:0] idx;
    logic signed [PW-1:0]         p;
    logic signed [ACC_W-1:0]      acc;
    logic signed [PW-1:0]         c_reg;
    logic                         busy_r;
    logic                         valid_r;

    logic signed [PW-1:0]         a_ext;
    logic signed [PW-1:0]         b_ext;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_W-1:0]      sum;
    logic signed [PW-1:0]         result;
    logic                         a_ok;
    logic                         b_ok;

    assign a_ok = ({1'b0, bus.a_addr} < N_LIM);
    assign b_ok = ({1'b0, bus.b_addr} < N_LIM);

    // Operands are sign-extended first so the truncated product is the
    // exact full-width signed product.
    always_comb begin
        a_ext = PW'(a_bank[idx]);
        b_ext = PW'(b_bank[idx]);
        prod  = a_ext * b_ext;
        sum   = acc + ACC_W'(p);
    end

`ifdef MAC_DOT_SAT_EN
    logic [ACC_W-PW:0] hi;
    logic              fits;

    // Fits when every bit above the result sign bit matches it.
    always_comb begin
        hi   = sum[ACC_W-1:PW-1];
        fits = (&hi) | ~(|hi);
        if (fits) begin
            result = sum[PW-1:0];
        end else if (sum[ACC_W-1]) begin
            result = {1'b1, {(PW-1){1'b0}}};
        end else begin
            result = {1'b0, {(PW-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^sum[ACC_W-1:PW];

    always_comb begin
        result = sum[PW-1:0];
    end
`endif

    // p is cleared on start so the first RUN edge adds zero; acc then
    // always accumulates the previous cycle's product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            p       <= '0;
            acc     <= '0;
            c_reg   <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            for (int k = 0; k < N; k++) begin
                a_bank[k] <= '0;
                b_bank[k] <= '0;
            end
        end else begin
            valid_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.a_wen && a_ok) begin
                        a_bank[bus.a_addr] <= bus.a_wdata;
                    end
                    if (bus.b_wen && b_ok) begin
                        b_bank[bus.b_addr] <= bus.b_wdata;
                    end
                    if (bus.start) begin
                        state  <= RUN;
                        idx    <= '0;
                        acc    <= '0;
                        p      <= '0;
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    p   <= prod;
                    acc <= sum;
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    c_reg   <= result;
                    valid_r <= 1'b1;
                    busy_r  <= 1'b0;
                    idx     <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.c_out   = c_reg;
    assign bus.c_valid = valid_r;
    assign bus.done    = valid_r;
endmodule

// File: tb/tb_mac_dot_product_engine.sv
// Scoreboard bench for mac_dot_product_engine (N=8 main, N=6 range).
// Expected results are queued at start and compared at done.
module tb_mac_dot_product_engine;
    localparam int N  = 8;
    localparam int N6 = 6;
    localparam int DW = 16;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mac_dot_product_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mac_dot_product_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus6 ();

    mac_dot_product_engine #(
        .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    mac_dot_product_engine #(
        .N(N6), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut6 (
        .clk(clk), .rst(rst), .bus(bus6)
    );

    int n_pass = 0;
    int n_chk  = 0;
    logic signed [2*DW-1:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_wdata = '0; bus.a_addr = '0; bus.a_wen = 1'b0;
        bus.b_wdata = '0; bus.b_addr = '0; bus.b_wen = 1'b0;
        bus.start = 1'b0;
        bus6.a_wdata = '0; bus6.a_addr = '0; bus6.a_wen = 1'b0;
        bus6.b_wdata = '0; bus6.b_addr = '0; bus6.b_wen = 1'b0;
        bus6.start = 1'b0;
    endtask

    task automatic load_ab(input int av, input bit ramp_b, input int bv);
        for (int k = 0; k < N; k++) begin
            bus.a_wen = 1'b1; bus.a_addr = AW'(k); bus.a_wdata = DW'(av);
            bus.b_wen = 1'b1; bus.b_addr = AW'(k);
            bus.b_wdata = ramp_b ? DW'(k + 1) : DW'(bv);
            tick();
        end
        bus.a_wen = 1'b0;
        bus.b_wen = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Observation only: latency in cycles after the start edge, and
    // whether busy stayed high until done.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.done) begin
                lat = c;
                return;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic signed [2*DW-1:0] e;
        int lat;
        bit bok;
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        n_chk++;
        if ({bus.busy, bus.c_valid, bus.done} !== 3'b000 || bus.c_out !== '0)
            $display("FAIL reset_outputs: busy=%b v=%b d=%b c=%0d want 0",
                     bus.busy, bus.c_valid, bus.done, bus.c_out);
        else n_pass++;
        exp_q.push_back('0);
        pulse_start();
        wait_done(lat, bok);
        e = exp_q.pop_front();
        n_chk++;
        if (lat != N + 1 || bus.c_out !== e)
            $display("FAIL reset_banks: lat=%0d c=%0d want lat=%0d c=%0d",
                     lat, bus.c_out, N + 1, e);
        else n_pass++;
    endtask

    task automatic test_ramp();
        logic signed [2*DW-1:0] e;
        int lat;
        bit bok;
        load_ab(1, 1'b1, 0);
        exp_q.push_back(36);
        pulse_start();
        n_chk++;
        if (bus.busy !== 1'b1)
            $display("FAIL ramp_busy_rise: got %b want 1", bus.busy);
        else n_pass++;
        wait_done(lat, bok);
        e = exp_q.pop_front();
        n_chk++;
        if (lat != N + 1 || !bok)
            $display("FAIL ramp_latency: lat=%0d busy_ok=%b want %0d/1",
                     lat, bok, N + 1);
        else n_pass++;
        n_chk++;
        if (bus.c_out !== e || bus.c_valid !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL ramp_result: c=%0d v=%b b=%b want %0d 1 0",
                     bus.c_out, bus.c_valid, bus.busy, e);
        else n_pass++;
        tick();
        n_chk++;
        if (bus.done !== 1'b0 || bus.c_valid !== 1'b0)
            $display("FAIL ramp_pulse_width: d=%b v=%b want 0 0",
                     bus.done, bus.c_valid);
        else n_pass++;
        tick(); tick();
        n_chk++;
        if (bus.c_out !== e)
            $display("FAIL ramp_hold: c=%0d want %0d", bus.c_out, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic signed [2*DW-1:0] e;
        int lat;
        bit bok;
        load_ab(-3, 1'b0, 2);
        exp_q.push_back(-48);
        pulse_start();
        wait_done(lat, bok);
        e = exp_q.pop_front();
        n_chk++;
        if (lat != N + 1 || bus.c_out !== e)
            $display("FAIL b2b_first: lat=%0d c=%0d want %0d %0d",
                     lat, bus.c_out, N + 1, e);
        else n_pass++;
        exp_q.push_back(-48);
        pulse_start();
        wait_done(lat, bok);
        e = exp_q.pop_front();
        n_chk++;
        if (lat != N + 1 || bus.c_out !== e || !bok)
            $display("FAIL b2b_second: lat=%0d c=%h want %0d %h",
                     lat, bus.c_out, N + 1, e);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic signed [2*DW-1:0] e;
        int lat;
        bit bok;
        load_ab(-32768, 1'b0, -32768);
`ifdef MAC_DOT_SAT_EN
        exp_q.push_back(32'sh7FFF_FFFF);
`else
        exp_q.push_back(32'sh0000_0000);
`endif
        pulse_start();
        wait_done(lat, bok);
        e = exp_q.pop_front();
        n_chk++;
        if (lat != N + 1 || bus.c_out !== e)
            $display("FAIL overflow: lat=%0d c=%h want %0d %h",
                     lat, bus.c_out, N + 1, e);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        logic signed [2*DW-1:0] e;
        int lat;
        int extra;
        bit bok;
        load_ab(1, 1'b1, 0);
        exp_q.push_back(36);
        pulse_start();
        tick(); tick(); tick();
        bus.start = 1'b1;
        bus.a_wen = 1'b1; bus.a_addr = '0; bus.a_wdata = 16'sd100;
        tick();
        bus.start = 1'b0;
        bus.a_wen = 1'b0;
        wait_done(lat, bok);
        e = exp_q.pop_front();
        n_chk++;
        if (lat + 4 != N + 1 || bus.c_out !== e)
            $display("FAIL busy_ignore_result: lat=%0d c=%0d want %0d %0d",
                     lat + 4, bus.c_out, N + 1, e);
        else n_pass++;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.done) extra++;
        end
        n_chk++;
        if (extra != 0)
            $display("FAIL busy_ignore_no_extra: extra dones=%0d want 0", extra);
        else n_pass++;
        exp_q.push_back(36);
        pulse_start();
        wait_done(lat, bok);
        e = exp_q.pop_front();
        n_chk++;
        if (bus.c_out !== e)
            $display("FAIL busy_ignore_frozen: c=%0d want %0d", bus.c_out, e);
        else n_pass++;
    endtask

    task automatic test_write_with_start();
        logic signed [2*DW-1:0] e;
        int lat;
        bit bok;
        exp_q.push_back(68);
        bus.a_wen = 1'b1; bus.a_addr = 3'd7; bus.a_wdata = 16'sd5;
        bus.start = 1'b1;
        tick();
        bus.a_wen = 1'b0;
        bus.start = 1'b0;
        wait_done(lat, bok);
        e = exp_q.pop_front();
        n_chk++;
        if (lat != N + 1 || bus.c_out !== e)
            $display("FAIL write_with_start: lat=%0d c=%0d want %0d %0d",
                     lat, bus.c_out, N + 1, e);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        logic signed [2*DW-1:0] e;
        int lat;
        int extra;
        bit bok;
        pulse_start();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c_out !== '0)
            $display("FAIL midrun_reset: b=%b d=%b c=%0d want 0 0 0",
                     bus.busy, bus.done, bus.c_out);
        else n_pass++;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.done) extra++;
        end
        n_chk++;
        if (extra != 0)
            $display("FAIL midrun_no_done: dones=%0d want 0", extra);
        else n_pass++;
        load_ab(1, 1'b1, 0);
        exp_q.push_back(36);
        pulse_start();
        wait_done(lat, bok);
        e = exp_q.pop_front();
        n_chk++;
        if (lat != N + 1 || bus.c_out !== e)
            $display("FAIL midrun_recover: lat=%0d c=%0d want %0d %0d",
                     lat, bus.c_out, N + 1, e);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic signed [2*DW-1:0] e;
        int lat;
        for (int k = 0; k < N6; k++) begin
            bus6.a_wen = 1'b1; bus6.a_addr = AW'(k); bus6.a_wdata = 16'sd1;
            bus6.b_wen = 1'b1; bus6.b_addr = AW'(k); bus6.b_wdata = DW'(k + 1);
            tick();
        end
        for (int k = N6; k < 8; k++) begin
            bus6.a_addr = AW'(k); bus6.a_wdata = 16'sd100;
            bus6.b_addr = AW'(k); bus6.b_wdata = 16'sd100;
            tick();
        end
        bus6.a_wen = 1'b0;
        bus6.b_wen = 1'b0;
        exp_q.push_back(21);
        bus6.start = 1'b1;
        tick();
        bus6.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus6.done) begin
                lat = c;
                break;
            end
        end
        e = exp_q.pop_front();
        n_chk++;
        if (lat != N6 + 1 || bus6.c_out !== e)
            $display("FAIL n6_out_of_range: lat=%0d c=%0d want %0d %0d",
                     lat, bus6.c_out, N6 + 1, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_overflow();
        load_ab(1, 1'b1, 0);
        test_busy_ignore();
        test_write_with_start();
        test_reset_midrun();
        test_out_of_range();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
